// File: rtl/fetch_realigner_if.sv
// Handshake bundle between the fetch stage and the realigner.
interface fetch_realigner_if #(
   parameter int FETCH_WIDTH = 64,
   parameter int VLEN        = 64
);
   localparam int IPF = FETCH_WIDTH / 16;

   logic                          flush_i;
   logic                          fetch_valid_i;
   logic                          fetch_ready_o;
   logic [VLEN-1:0]               fetch_addr_i;
   logic [FETCH_WIDTH-1:0]        fetch_data_i;
   logic [IPF-1:0]                instr_valid_o;
   logic [IPF-1:0][VLEN-1:0]      instr_addr_o;
   logic [IPF-1:0][31:0]          instr_o;
   logic                          instr_ready_i;
   logic                          serving_unaligned_o;

   modport slave (
      input  flush_i, fetch_valid_i, fetch_addr_i, fetch_data_i, instr_ready_i,
      output fetch_ready_o, instr_valid_o, instr_addr_o, instr_o, serving_unaligned_o
   );

   modport master (
      output flush_i, fetch_valid_i, fetch_addr_i, fetch_data_i, instr_ready_i,
      input  fetch_ready_o, instr_valid_o, instr_addr_o, instr_o, serving_unaligned_o
   );
endinterface

// File: rtl/fetch_realigner.sv
// Splits aligned fetch blocks into up to IPF RVI/RVC instructions; REALIGN_PERF_EN adds perf_straddle_o.
// Latency: zero cycles, outputs are combinational from the current block and the carry register.
// Backpressure: block consumed on fetch_valid_i & fetch_ready_o; carry holds while not consumed.
module fetch_realigner #(
   parameter int FETCH_WIDTH = 64,
   parameter int VLEN        = 64
) (
   input  logic               clk_i,
   input  logic               rst_i,
`ifdef REALIGN_PERF_EN
   output logic [31:0]        perf_straddle_o,
`endif
   fetch_realigner_if.slave   bus
);
   localparam int IPF  = FETCH_WIDTH / 16;
   localparam int OFFW = $clog2(FETCH_WIDTH / 8);
   localparam int SW   = $clog2(IPF);

   logic [IPF-1:0][15:0]     hw;
   logic [SW-1:0]            h0;
   logic [VLEN-1:0]          base;

   logic                     carry_q;
   logic [15:0]              carry_instr_q;
   logic [VLEN-1:0]          carry_addr_q;

   logic [IPF-1:0]           slot_vld;
   logic [IPF-1:0][31:0]     slot_dat;
   logic [IPF-1:0][VLEN-1:0] slot_addr;
   logic                     carry_nxt;
   logic                     show;
   logic                     consume;

   assign hw   = bus.fetch_data_i;
   assign h0   = bus.fetch_addr_i[OFFW-1:1];
   assign base = bus.fetch_addr_i & ~(VLEN'(FETCH_WIDTH / 8) - VLEN'(1));

   always_comb begin
      logic [SW-1:0] n;
      logic          skip;
      slot_vld  = '0;
      slot_dat  = '0;
      slot_addr = '0;
      carry_nxt = 1'b0;
      n         = '0;
      skip      = 1'b0;
      // A carried upper half only joins a block that continues at halfword 0.
      if (carry_q && h0 == '0) begin
         slot_vld[0]  = 1'b1;
         slot_dat[0]  = {hw[0], carry_instr_q};
         slot_addr[0] = carry_addr_q;
         n            = SW'(1);
         skip         = 1'b1;
      end
      for (int k = 0; k < IPF; k++) begin
         if (skip) begin
            skip = 1'b0;
         end else if (SW'(k) >= h0) begin
            if (hw[k][1:0] != 2'b11) begin
               slot_vld[n]  = 1'b1;
               slot_dat[n]  = {16'h0000, hw[k]};
               slot_addr[n] = base + VLEN'(2 * k);
               n            = n + SW'(1);
            end else if (k < IPF - 1) begin
               slot_vld[n]  = 1'b1;
               slot_dat[n]  = {hw[(k + 1) % IPF], hw[k]};
               slot_addr[n] = base + VLEN'(2 * k);
               n            = n + SW'(1);
               skip         = 1'b1;
            end else begin
               carry_nxt = 1'b1;
            end
         end
      end
   end

   assign show    = bus.fetch_valid_i & ~bus.flush_i;
   assign consume = bus.fetch_valid_i & bus.fetch_ready_o;

   assign bus.instr_valid_o       = show ? slot_vld  : '0;
   assign bus.instr_o             = show ? slot_dat  : '0;
   assign bus.instr_addr_o        = show ? slot_addr : '0;
   // A block yielding no slots only feeds the carry, so it never waits on downstream.
   assign bus.fetch_ready_o       = bus.instr_ready_i | bus.flush_i | (bus.fetch_valid_i & ~|slot_vld);
   assign bus.serving_unaligned_o = carry_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         carry_q       <= 1'b0;
         carry_instr_q <= '0;
         carry_addr_q  <= '0;
      end else if (bus.flush_i) begin
         carry_q <= 1'b0;
      end else if (consume) begin
         carry_q       <= carry_nxt;
         carry_instr_q <= hw[IPF-1];
         carry_addr_q  <= base + VLEN'(2 * (IPF - 1));
      end
   end

`ifdef REALIGN_PERF_EN
   logic [31:0] perf_q;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         perf_q <= '0;
      end else if (consume && !bus.flush_i && carry_nxt && perf_q != 32'hFFFF_FFFF) begin
         perf_q <= perf_q + 32'd1;
      end
   end

   assign perf_straddle_o = perf_q;
`endif
endmodule
